// File: rtl/carrega_programa.sv
// Program loader: receives a length byte followed by little-endian instruction bytes
// and writes each assembled 32-bit word into instruction memory while holding the core in reset.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LEN   | waiting for the word-count byte
// BYTES | assembling the current word from 4 bytes
// WRITE | one-cycle instruction-memory write strobe
// DONE  | load complete, core released
// ERRO  | load aborted (bad length or timeout)
module carrega_programa (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mi_we,
  output logic [5:0]  mi_ender,
  output logic [31:0] mi_dado,
  output logic        core_rst,
  output logic        done,
  output logic        erro,
  output logic [6:0]  word_count
);

  typedef enum logic [2:0] {IDLE, LEN, BYTES, WRITE, DONE, ERRO} state_t;

  state_t      state;
  state_t      nxt;
  logic [6:0]  n_words;
  logic [1:0]  idx;
  logic [7:0]  tmo;
  logic [23:0] word_lo;
  logic        rx_phase;
  logic        xfer;
  logic        tmo_hit;
  logic        len_ok;
  logic [6:0]  wc_inc;

  assign rx_phase = (state == LEN) || (state == BYTES);
  assign xfer     = rx_phase && byte_valid;
  // Counter would reach 255 on this edge; a transfer in the same cycle takes priority.
  assign tmo_hit  = rx_phase && !byte_valid && (tmo == 8'd254);
  assign len_ok   = (byte_in != 8'd0) && (byte_in <= 8'd64);
  assign wc_inc   = word_count + 7'd1;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = LEN;
      LEN: begin
        if (xfer)         nxt = len_ok ? BYTES : ERRO;
        else if (tmo_hit) nxt = ERRO;
      end
      BYTES: begin
        if (xfer) begin
          if (idx == 2'd3) nxt = WRITE;
        end else if (tmo_hit) begin
          nxt = ERRO;
        end
      end
      WRITE: nxt = (wc_inc == n_words) ? DONE : BYTES;
      DONE:  if (start) nxt = LEN;
      ERRO:  if (start) nxt = LEN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mi_we      <= 1'b0;
      mi_ender   <= 6'd0;
      mi_dado    <= 32'd0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      erro       <= 1'b0;
      word_count <= 7'd0;
      n_words    <= 7'd0;
      idx        <= 2'd0;
      tmo        <= 8'd0;
      word_lo    <= 24'd0;
    end else begin
      state      <= nxt;
      byte_ready <= (nxt == LEN) || (nxt == BYTES);
      mi_we      <= (nxt == WRITE);
      core_rst   <= (nxt != DONE);
      done       <= (nxt == DONE);
      erro       <= (nxt == ERRO);

      if (nxt != state)  tmo <= 8'd0;
      else if (rx_phase) tmo <= xfer ? 8'd0 : tmo + 8'd1;

      if (nxt == LEN && state != LEN) begin
        word_count <= 7'd0;
        idx        <= 2'd0;
      end

      if (state == LEN && xfer) n_words <= byte_in[6:0];

      if (state == BYTES && xfer) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0: word_lo[7:0]   <= byte_in;
          2'd1: word_lo[15:8]  <= byte_in;
          2'd2: word_lo[23:16] <= byte_in;
          default: begin
            mi_dado  <= {byte_in, word_lo};
            mi_ender <= word_count[5:0];
          end
        endcase
      end

      if (state == WRITE) word_count <= wc_inc;
    end
  end

endmodule

// File: tb/tb_carrega_programa.sv
// Directed bench for carrega_programa: expected memory writes go into a scoreboard
// queue that a negedge monitor drains; status outputs are checked at fixed points.
module tb_carrega_programa;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mi_we;
  logic [5:0]  mi_ender;
  logic [31:0] mi_dado;
  logic        core_rst;
  logic        done;
  logic        erro;
  logic [6:0]  word_count;

  int errors = 0;
  int checks = 0;
  logic [37:0] exp_q[$];

  carrega_programa dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mi_we(mi_we),
    .mi_ender(mi_ender), .mi_dado(mi_dado), .core_rst(core_rst),
    .done(done), .erro(erro), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the next expected (address, data).
  always @(negedge clk) begin
    if (mi_we) begin
      logic [37:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", mi_ender, mi_dado);
      end else begin
        e = exp_q.pop_front();
        if ({mi_ender, mi_dado} !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mi_ender, mi_dado, e[37:32], e[31:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present a byte and hold it until it is accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   n;
    byte_in    = b;
    byte_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0]);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    step(2);
    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mi_we",      32'(mi_we),      32'd0);
    chk("rst_mi_ender",   32'(mi_ender),   32'd0);
    chk("rst_mi_dado",    mi_dado,         32'd0);
    chk("rst_core_rst",   32'(core_rst),   32'd1);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_erro",       32'(erro),       32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    step(1);

    // Nominal load, byte_valid held high (byte 5 waits through WRITE)
    expect_write(6'd0, 32'h0020_8093);
    expect_write(6'd1, 32'h0000_8093);
    pulse_start();
    chk("len_byte_ready", 32'(byte_ready), 32'd1);
    send_byte(8'd2);
    send_byte(8'h93); send_byte(8'h80); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h80); send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    step(2);
    chk("nom_done",       32'(done),       32'd1);
    chk("nom_core_rst",   32'(core_rst),   32'd0);
    chk("nom_word_count", 32'(word_count), 32'd2);
    chk("nom_byte_ready", 32'(byte_ready), 32'd0);
    step(3);
    chk("done_hold_wc",   32'(word_count), 32'd2);

    // Reload from DONE
    pulse_start();
    chk("reload_wc_clr",   32'(word_count), 32'd0);
    chk("reload_done_clr", 32'(done),       32'd0);
    chk("reload_core_rst", 32'(core_rst),   32'd1);
    expect_write(6'd0, 32'hCAFE_F00D);
    send_byte(8'd1);
    send_word(32'hCAFE_F00D);
    byte_valid = 1'b0;
    step(2);
    chk("reload_wc",   32'(word_count), 32'd1);
    chk("reload_done", 32'(done),       32'd1);

    // Bad lengths
    pulse_start();
    send_byte(8'd0);
    byte_valid = 1'b0;
    chk("n0_erro",     32'(erro),       32'd1);
    chk("n0_core_rst", 32'(core_rst),   32'd1);
    chk("n0_ready",    32'(byte_ready), 32'd0);
    step(3);
    pulse_start();
    chk("erro_clr_on_start", 32'(erro), 32'd0);
    send_byte(8'd65);
    byte_valid = 1'b0;
    chk("n65_erro",     32'(erro),     32'd1);
    chk("n65_core_rst", 32'(core_rst), 32'd1);
    pulse_start();
    send_byte(8'd64);
    byte_valid = 1'b0;
    chk("n64_accepted_ready", 32'(byte_ready), 32'd1);
    chk("n64_accepted_erro",  32'(erro),       32'd0);
    reset = 1'b1; step(1); reset = 1'b0;

    // Timeout after 255 idle cycles
    pulse_start();
    send_byte(8'd1); send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    step(254);
    chk("tmo_254_no_erro", 32'(erro), 32'd0);
    step(1);
    chk("tmo_255_erro",     32'(erro),     32'd1);
    chk("tmo_255_core_rst", 32'(core_rst), 32'd1);

    // Transfer on the 255th idle cycle wins over the timeout
    pulse_start();
    send_byte(8'd1); send_byte(8'h11); send_byte(8'h22);
    byte_valid = 1'b0;
    step(254);
    send_byte(8'h33);
    byte_valid = 1'b0;
    chk("tmo_xfer_erro",  32'(erro),       32'd0);
    chk("tmo_xfer_ready", 32'(byte_ready), 32'd1);
    expect_write(6'd0, 32'h4433_2211);
    send_byte(8'h44);
    byte_valid = 1'b0;
    step(2);
    chk("tmo_xfer_done", 32'(done), 32'd1);

    // Throttled source, start pulsed mid-word (ignored)
    expect_write(6'd0, 32'hDEAD_BEEF);
    expect_write(6'd1, 32'h1234_5678);
    expect_write(6'd2, 32'hA5A5_0F0F);
    pulse_start();
    send_byte(8'd3);
    begin
      logic [31:0] words [3];
      words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678; words[2] = 32'hA5A5_0F0F;
      for (int i = 0; i < 12; i++) begin
        logic [31:0] t;
        t = words[i / 4] >> (8 * (i % 4));
        if (i % 8 != 4) begin
          byte_valid = 1'b0;
          if (i == 2) start = 1'b1;
          step(1);
          start = 1'b0;
        end
        send_byte(t[7:0]);
      end
    end
    byte_valid = 1'b0;
    step(2);
    chk("thr_done", 32'(done),       32'd1);
    chk("thr_wc",   32'(word_count), 32'd3);

    // Reset mid-load after first word of four
    pulse_start();
    expect_write(6'd0, 32'h0102_0304);
    send_byte(8'd4);
    send_word(32'h0102_0304);
    byte_valid = 1'b0;
    step(1);
    send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 1'b0;
    reset = 1'b1; step(1); reset = 1'b0;
    chk("mid_rst_wc",       32'(word_count), 32'd0);
    chk("mid_rst_core_rst", 32'(core_rst),   32'd1);
    chk("mid_rst_ready",    32'(byte_ready), 32'd0);
    chk("mid_rst_dado",     mi_dado,         32'd0);
    step(5);
    chk("mid_rst_idle_ready", 32'(byte_ready), 32'd0);

    // Reset during WRITE suppresses further strobes
    pulse_start();
    expect_write(6'd0, 32'h7766_5544);
    send_byte(8'd2);
    send_word(32'h7766_5544);
    byte_valid = 1'b0;
    chk("wr_mi_we_high", 32'(mi_we), 32'd1);
    reset = 1'b1; step(1);
    chk("wr_rst_mi_we", 32'(mi_we), 32'd0);
    reset = 1'b0;
    step(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
